// File: rtl/accumulate_pkg.sv
// accumulate_pkg
//   Shared definitions for the partial-sum accumulator: FSM state encoding,
//   job-mode constants and the default widths derived from the PE datapath
//   (DATA_WIDTH operands, BIAS_WIDTH accumulator).
package accumulate_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int BIAS_WIDTH = 32;

   localparam int DEF_NUM_LANES = 3;
   localparam int DEF_PSUM_W    = DATA_WIDTH * 2 + 2;
   localparam int DEF_ACC_W     = BIAS_WIDTH;
   localparam int DEF_LEN_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_FC   = 2'd2
   } state_t;

   localparam logic MODE_CONV = 1'b0;
   localparam logic MODE_FC   = 1'b1;

endpackage

// File: rtl/accumulate_pipe_if.sv
// accumulate_pipe_if
//   Bundles the job controls, the psum input stream and the result stream of
//   accumulate_pipe.
//   Handshake: a beat transfers on a rising clk edge where in_valid && in_ready;
//   a result transfers where out_valid && out_ready. A valid side holds its
//   payload stable until the transfer happens.
//   Modports: master = producer/consumer side (PE array + writeback),
//             slave  = the accumulator itself.
//   state_dbg exposes the accumulator FSM state for observation.
interface accumulate_pipe_if
   import accumulate_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int PSUM_W    = DEF_PSUM_W,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int LEN_W     = DEF_LEN_W
) ();

   logic                        mode;
   logic [LEN_W-1:0]            fc_len;
   logic [ACC_W-1:0]            bias;
   logic                        in_valid;
   logic                        in_ready;
   logic                        in_last;
   logic [NUM_LANES*PSUM_W-1:0] psum;
   logic                        out_valid;
   logic                        out_ready;
   logic [ACC_W-1:0]            sum;
   logic                        sat_flag;
   logic                        fc_line_done;
   logic                        busy;
   logic [1:0]                  state_dbg;

   modport master (
      output mode, fc_len, bias, in_valid, in_last, psum, out_ready,
      input  in_ready, out_valid, sum, sat_flag, fc_line_done, busy, state_dbg
   );

   modport slave (
      input  mode, fc_len, bias, in_valid, in_last, psum, out_ready,
      output in_ready, out_valid, sum, sat_flag, fc_line_done, busy, state_dbg
   );

endinterface

// File: rtl/accumulate_pipe_sat_add.sv
// sat_add
//   Adds an ACC_W-bit operand (bias or running accumulator) to an
//   ACC_W+1-bit lane sum, with overflow detection and optional clamping.
//   Ports:
//     a      in  ACC_W    bias or accumulator
//     b      in  ACC_W+1  extended lane sum
//     result out ACC_W    clamped (SATURATE=1) or wrapped (SATURATE=0) sum
//     ovf    out 1        sum does not fit in ACC_W bits
module sat_add #(
   parameter int ACC_W    = 32,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 1
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W:0]   b,
   output logic [ACC_W-1:0] result,
   output logic             ovf
);

   // Two guard bits: b is already one bit wider than a, so the exact sum
   // needs ACC_W+2 bits to never wrap internally.
   localparam int W = ACC_W + 2;

   logic [W-1:0] a_x;
   logic [W-1:0] b_x;
   logic [W-1:0] full;
   logic [2:0]   top;

   always_comb begin
      if (SIGNED != 0) begin
         a_x = {{2{a[ACC_W-1]}}, a};
         b_x = {b[ACC_W], b};
      end else begin
         a_x = {2'b00, a};
         b_x = {1'b0, b};
      end
      full = a_x + b_x;
      top  = full[W-1:ACC_W-1];

      if (SIGNED != 0) begin
         // Representable only when the guard bits replicate the sign bit.
         ovf = !((&top) || !(|top));
      end else begin
         ovf = |top[2:1];
      end

      if (ovf && (SATURATE != 0)) begin
         if (SIGNED != 0) begin
            result = full[W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end else begin
            result = {ACC_W{1'b1}};
         end
      end else begin
         result = full[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/accumulate_pipe.sv
// accumulate_pipe
//   Reduces NUM_LANES partial sums per beat and adds a bias. CONV jobs emit
//   one result per beat; FC jobs accumulate fc_len beats (or up to in_last)
//   into one result per line.
//   Ports:
//     clk  in  rising-edge clock
//     rst  in  asynchronous active-low reset
//     bus  accumulate_pipe_if.slave: job controls (mode, fc_len, bias),
//          psum beat stream (in_valid/in_ready/in_last/psum), result stream
//          (out_valid/out_ready/sum/sat_flag), fc_line_done pulse, busy and
//          state_dbg.
module accumulate_pipe
   import accumulate_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int PSUM_W    = DEF_PSUM_W,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int LEN_W     = DEF_LEN_W,
   parameter int SIGNED    = 0,
   parameter int SATURATE  = 1
) (
   input logic              clk,
   input logic              rst,
   accumulate_pipe_if.slave bus
);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [LEN_W-1:0] fc_len_q, fc_len_d;
   logic             line_sat_q, line_sat_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic             sat_flag_q, sat_flag_d;
   logic             fc_line_done_q, fc_line_done_d;

   logic [ACC_W:0]   lane_sum;
   logic [ACC_W-1:0] add_a;
   logic [ACC_W-1:0] add_res;
   logic             add_ovf;
   logic             fc_beat;
   logic             fc_cont;
   logic [LEN_W-1:0] len_src;
   logic [LEN_W:0]   len_eff;
   logic [LEN_W:0]   cnt_next;
   logic             line_end;
   logic             sat_res;
   logic             in_ready_w;
   logic             accept;

   function automatic logic [ACC_W:0] ext_lane(input logic [PSUM_W-1:0] v);
      if (SIGNED != 0) begin
         return {{(ACC_W + 1 - PSUM_W){v[PSUM_W-1]}}, v};
      end else begin
         return {{(ACC_W + 1 - PSUM_W){1'b0}}, v};
      end
   endfunction

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_sum = lane_sum + ext_lane(bus.psum[i*PSUM_W +: PSUM_W]);
      end
   end

   // A beat belongs to an FC line when we are already in FC, or when it
   // opens an FC job from IDLE. fc_cont marks beats after the first of a line.
   assign fc_beat = (state_q == ST_FC) || ((state_q == ST_IDLE) && (bus.mode == MODE_FC));
   assign fc_cont = (state_q == ST_FC) && (beat_cnt_q != '0);

   // The first beat of a line decides its length from the live fc_len.
   assign len_src  = fc_cont ? fc_len_q : bus.fc_len;
   assign len_eff  = (len_src == '0) ? (LEN_W + 1)'(1) : {1'b0, len_src};
   assign cnt_next = {1'b0, beat_cnt_q} + (LEN_W + 1)'(1);
   assign line_end = bus.in_last || (cnt_next == len_eff);

   assign add_a   = fc_cont ? acc_q : bus.bias;
   assign sat_res = add_ovf || (fc_cont && line_sat_q);

   sat_add #(
      .ACC_W   (ACC_W),
      .SIGNED  (SIGNED),
      .SATURATE(SATURATE)
   ) u_sat_add (
      .a     (add_a),
      .b     (lane_sum),
      .result(add_res),
      .ovf   (add_ovf)
   );

   // Non-final FC beats never touch the output register, so they may be
   // taken even while a result is stalled downstream.
   assign in_ready_w = !out_valid_q || bus.out_ready || (fc_beat && !line_end);
   assign accept     = bus.in_valid && in_ready_w;

   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      beat_cnt_d     = beat_cnt_q;
      fc_len_d       = fc_len_q;
      line_sat_d     = line_sat_q;
      out_valid_d    = out_valid_q && !bus.out_ready;
      sum_d          = sum_q;
      sat_flag_d     = sat_flag_q;
      fc_line_done_d = 1'b0;

      if (accept) begin
         if (!fc_beat) begin
            sum_d       = add_res;
            sat_flag_d  = add_ovf;
            out_valid_d = 1'b1;
            state_d     = bus.in_last ? ST_IDLE : ST_CONV;
         end else begin
            if (!fc_cont) begin
               fc_len_d = bus.fc_len;
            end
            if (line_end) begin
               sum_d          = add_res;
               sat_flag_d     = sat_res;
               out_valid_d    = 1'b1;
               fc_line_done_d = 1'b1;
               acc_d          = '0;
               beat_cnt_d     = '0;
               line_sat_d     = 1'b0;
               state_d        = bus.in_last ? ST_IDLE : ST_FC;
            end else begin
               acc_d      = add_res;
               line_sat_d = sat_res;
               beat_cnt_d = beat_cnt_q + LEN_W'(1);
               state_d    = ST_FC;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         acc_q          <= '0;
         beat_cnt_q     <= '0;
         fc_len_q       <= '0;
         line_sat_q     <= 1'b0;
         out_valid_q    <= 1'b0;
         sum_q          <= '0;
         sat_flag_q     <= 1'b0;
         fc_line_done_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         beat_cnt_q     <= beat_cnt_d;
         fc_len_q       <= fc_len_d;
         line_sat_q     <= line_sat_d;
         out_valid_q    <= out_valid_d;
         sum_q          <= sum_d;
         sat_flag_q     <= sat_flag_d;
         fc_line_done_q <= fc_line_done_d;
      end
   end

   assign bus.in_ready     = in_ready_w;
   assign bus.out_valid    = out_valid_q;
   assign bus.sum          = sum_q;
   assign bus.sat_flag     = sat_flag_q;
   assign bus.fc_line_done = fc_line_done_q;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.state_dbg    = state_q;

endmodule
